// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator slice.
// Holds the FSM state type and the default counter widths so that the
// top module and its down counter agree on them.
package pulse_pkg;

    localparam int DEFAULT_CNT_W = 16;
    localparam int DEFAULT_NUM_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_GAP   = 2'd3
    } pulse_state_e;

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down counter with a zero flag.
// The pulse generator reuses one of these for its delay, width and gap
// phases, so it only ever needs to load a phase length and count it out.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous, active-low; clears the count
//   load     - load load_val this cycle (wins over dec)
//   dec      - decrement by one; holds at zero instead of wrapping
//   load_val - value loaded when load=1
//   zero     - high while the count is zero
module pulse_down_counter
    import pulse_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Count register. Decrementing stops at zero so an all-ones load is a
    // legal maximum and the counter can never wrap around.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_generator.sv
// Programmable pulse-train generator.
// After an accepted start it waits delay_cyc cycles, then emits
// max(pulse_num,1) pulses, each max(width_cyc,1) cycles high and separated
// by max(gap_cyc,1) low cycles. The configuration is captured at start so
// later input changes do not disturb the running train.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-low
//   start     - train request, only looked at while idle
//   abort     - cancels the active train (no done strobe)
//   delay_cyc - cycles from start acceptance to the first rising edge
//   width_cyc - high time per pulse
//   gap_cyc   - low time between pulses
//   pulse_num - pulses per train
//   sig_out   - registered pulse train
//   busy      - registered, high while a train is active
//   done      - registered one-cycle strobe on normal completion
module pulse_generator
    import pulse_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W,
    parameter int NUM_W = DEFAULT_NUM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] delay_cyc,
    input  logic [CNT_W-1:0] width_cyc,
    input  logic [CNT_W-1:0] gap_cyc,
    input  logic [NUM_W-1:0] pulse_num,
    output logic             sig_out,
    output logic             busy,
    output logic             done
);

    pulse_state_e     state;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_q;
    logic [NUM_W-1:0] pulses_left;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    // The edge that enters a HIGH or GAP phase already counts as that
    // phase's first cycle, so the counter is loaded with length-1.
    // A zero length is treated as one cycle.
    function automatic logic [CNT_W-1:0] phase_reload(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    pulse_down_counter #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Phase counter control. The delay is loaded raw at acceptance: the
    // first DELAY edge sees the full value, which puts the first rising
    // edge delay cycles after the acceptance edge plus one.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cnt_val  = delay_cyc;
                end
            end
            ST_DELAY, ST_GAP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = phase_reload(width_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_zero) begin
                    if (pulses_left != '0) begin
                        cnt_load = 1'b1;
                        cnt_val  = phase_reload(gap_q);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
        if ((state != ST_IDLE) && abort) begin
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    // Main FSM with registered outputs. In IDLE a start always wins over
    // abort; outside IDLE an abort drops straight back to IDLE without a
    // done strobe. pulses_left counts the pulses still to come after the
    // current one, so zero on a HIGH expiry means the train is finished.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sig_out     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            width_q     <= '0;
            gap_q       <= '0;
            pulses_left <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    width_q     <= width_cyc;
                    gap_q       <= gap_cyc;
                    pulses_left <= (pulse_num == '0) ? '0 : pulse_num - NUM_W'(1);
                    busy        <= 1'b1;
                    state       <= ST_DELAY;
                end
            end else if (abort) begin
                state   <= ST_IDLE;
                sig_out <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_DELAY, ST_GAP: begin
                        if (cnt_zero) begin
                            sig_out <= 1'b1;
                            state   <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_zero) begin
                            sig_out <= 1'b0;
                            if (pulses_left == '0) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                pulses_left <= pulses_left - NUM_W'(1);
                                state       <= ST_GAP;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pulse_generator.md
PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the delay, width and gap counters.
REQ-002 The block SHALL have parameter NUM_W, default 8, giving the width of the pulse-count field.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 Port start, input, 1 bit: a train request, sampled only while busy=0.
REQ-006 Port abort, input, 1 bit: a synchronous request to cancel the active train.
REQ-007 Port delay_cyc, input, CNT_W bits: cycles from start acceptance to the first rising edge.
REQ-008 Port width_cyc, input, CNT_W bits: high time of each pulse, in cycles.
REQ-009 Port gap_cyc, input, CNT_W bits: low time between consecutive pulses, in cycles.
REQ-010 Port pulse_num, input, NUM_W bits: number of pulses in the train.
REQ-011 Port sig_out, output, 1 bit: the generated pulse train.
REQ-012 Port busy, output, 1 bit: high while a train is active.
REQ-013 Port done, output, 1 bit: a 1-cycle strobe when a train completes normally.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have states IDLE, DELAY, HIGH, GAP.
REQ-016 In IDLE, start=1 at edge E SHALL latch delay_cyc, width_cyc, gap_cyc and pulse_num, set busy=1 from E, and enter DELAY.
REQ-017 Changes to the configuration inputs after acceptance SHALL have no effect on the active train.
REQ-018 start SHALL be ignored while busy=1; no request is queued.
REQ-019 sig_out SHALL first go high at edge E+1+delay; delay=0 gives sig_out high at E+1.
REQ-020 Each pulse SHALL be high for exactly max(width,1) cycles.
REQ-021 Pulses SHALL be separated by exactly max(gap,1) low cycles.
REQ-022 The train SHALL contain exactly max(pulse_num,1) pulses; pulse_num=0 is treated as 1.
REQ-023 Transitions: IDLE->DELAY on start; DELAY->HIGH when the delay count expires; HIGH->GAP when width expires and pulses remain; HIGH->IDLE when width expires on the last pulse; GAP->HIGH when the gap expires.
REQ-024 On the edge where the last pulse's sig_out falls, done SHALL be 1 for one cycle and busy SHALL go 0 on that same edge.
REQ-025 start SHALL be accepted in the cycle in which done=1, giving back-to-back trains.
REQ-026 abort=1 while busy SHALL force sig_out=0 and busy=0 on the next edge and return the FSM to IDLE, with no done.
REQ-027 abort in IDLE SHALL have no effect.
REQ-028 If start and abort are both 1 in IDLE, start SHALL win.
REQ-029 Counters SHALL count down from the latched value and never wrap; the all-ones value is a legal maximum.

Reset
REQ-030 While reset=0 at a rising clk edge: FSM=IDLE, sig_out=0, busy=0, done=0, counters=0.
REQ-031 Reset mid-train SHALL terminate the train with no done.
REQ-032 A start asserted while reset=0 SHALL be ignored.

Structure
REQ-033 A shared package pulse_pkg SHALL hold the FSM state enum typedef and the default CNT_W/NUM_W constants.
REQ-034 One sub-module, pulse_down_counter, SHALL be used: CNT_W-bit load/decrement with a zero flag, reused for the delay, width and gap phases.
REQ-035 The pulse-count counter SHALL be in the top module.

Verification
REQ-036 Single pulse: start at E with delay=3, width=2, num=1 -> sig_out high at E+4 and E+5, low at E+6, done=1 at E+6.
REQ-037 Train: delay=0, width=1, gap=2, num=3 -> sig_out pattern 1,0,0,1,0,0,1 starting at E+1; done with the final fall.
REQ-038 Zero fields: width=0, gap=0, num=0 -> exactly one 1-cycle pulse; no hang.
REQ-039 Abort: start, then abort during the 2nd HIGH of num=4 -> sig_out=0 and busy=0 next edge, done never asserted.
REQ-040 Reset mid-GAP: reset=0 for one edge -> all outputs 0; start held during reset is ignored; a later start runs a normal train.
REQ-041 Back-to-back and ignore: start held high continuously -> a new train begins in the done cycle; start pulses while busy do not change the active train.
